// File: rtl/if_fetch_buffer_pkg.sv
// if_fetch_buffer_pkg: shared constants and helpers for the instruction-fetch buffer
package if_fetch_buffer_pkg;

    // Fetch address used when the core comes out of reset
    localparam logic [31:0] RESET_PC_DEF = 32'h0;

    // Low two bits of a halfword that mark the start of a 32-bit instruction
    localparam logic [1:0] FULL_OPC = 2'b11;

    function automatic logic is_full(input logic [15:0] hw);
        return hw[1:0] == FULL_OPC;
    endfunction

endpackage

// File: rtl/if_fetch_buffer_hw_fifo.sv
// if_fetch_buffer_hw_fifo: halfword FIFO with 0/1/2-entry push and pop plus synchronous clear
// Ports:
//   clk, resetn         clock, asynchronous active-low reset
//   i_clear             empty the FIFO (wins over push and pop)
//   i_push_n            number of halfwords to write (0..2); i_push_data[15:0] is written first
//   i_pop_n             number of halfwords to drop from the head (0..2)
//   o_count             occupancy in halfwords (0..DEPTH)
//   o_head0, o_head1    oldest and second-oldest halfword (content undefined past o_count)
module if_fetch_buffer_hw_fifo #(
    parameter  int DEPTH = 8,
    localparam int AW    = $clog2(DEPTH),
    localparam int CW    = AW + 1
) (
    input  logic          clk,
    input  logic          resetn,
    input  logic          i_clear,
    input  logic [1:0]    i_push_n,
    input  logic [31:0]   i_push_data,
    input  logic [1:0]    i_pop_n,
    output logic [CW-1:0] o_count,
    output logic [15:0]   o_head0,
    output logic [15:0]   o_head1
);

    logic [15:0]   r_mem [DEPTH];
    logic [AW-1:0] r_rd;
    logic [AW-1:0] r_wr;
    logic [CW-1:0] r_count;

    // Pointers are AW bits wide, so the power-of-two depth makes them wrap for free
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_rd    <= '0;
            r_wr    <= '0;
            r_count <= '0;
        end else if (i_clear) begin
            r_rd    <= '0;
            r_wr    <= '0;
            r_count <= '0;
        end else begin
            r_rd    <= r_rd + AW'(i_pop_n);
            r_wr    <= r_wr + AW'(i_push_n);
            r_count <= r_count + CW'(i_push_n) - CW'(i_pop_n);
        end
    end

    always_ff @(posedge clk) begin
        if (!i_clear && i_push_n != 2'd0)
            r_mem[r_wr] <= i_push_data[15:0];
        if (!i_clear && i_push_n == 2'd2)
            r_mem[r_wr + AW'(1)] <= i_push_data[31:16];
    end

    assign o_count = r_count;
    assign o_head0 = r_mem[r_rd];
    assign o_head1 = r_mem[r_rd + AW'(1)];

endmodule

// File: rtl/if_fetch_buffer.sv
// if_fetch_buffer: instruction-fetch stage feeding decode from a halfword FIFO of fetched words
// Ports:
//   clk, resetn                      clock, asynchronous active-low reset
//   imem_req_o / imem_addr_o         word request valid and word-aligned address
//   imem_ready_i                     request accepted when imem_req_o & imem_ready_i
//   imem_rvalid_i / imem_rdata_i     in-order response, halfword 0 in [15:0]
//   enable_i                         decode may consume this cycle
//   is_compressed_d_i                head instruction is 16-bit (pop 1) else pop 2
//   taken_d_i / redirection_d_i      redirect request and halfword-aligned target
//   instruction_f_o                  {hw1, hw0} of the head, zero when not valid
//   instr_valid_f_o                  head holds a complete instruction
module if_fetch_buffer
    import if_fetch_buffer_pkg::*;
#(
    parameter int          DEPTH_HW = 8,
    parameter logic [31:0] RESET_PC = RESET_PC_DEF
) (
    input  logic        clk,
    input  logic        resetn,
    output logic        imem_req_o,
    output logic [31:0] imem_addr_o,
    input  logic        imem_ready_i,
    input  logic        imem_rvalid_i,
    input  logic [31:0] imem_rdata_i,
    input  logic        enable_i,
    input  logic        is_compressed_d_i,
    input  logic        taken_d_i,
    input  logic [31:0] redirection_d_i,
    output logic [31:0] instruction_f_o,
    output logic        instr_valid_f_o
);

    localparam int CW = $clog2(DEPTH_HW) + 1;

    logic [31:0]   r_fetch_pc;
    logic          r_skip_hw;
    logic          r_run;
    logic [1:0]    r_outst;
    logic [1:0]    r_drop;

    logic [CW-1:0] w_count;
    logic [15:0]   w_head0;
    logic [15:0]   w_head1;
    logic [1:0]    w_live;
    logic [1:0]    w_push_n;
    logic [1:0]    w_pop_n;
    logic [CW+1:0] w_need;
    logic          w_accept;
    logic          w_push;
    logic          w_many;
    logic          w_consume;

    // Live requests will each land two halfwords, so their space is reserved up front
    assign w_live      = r_outst - r_drop;
    assign w_need      = (CW+2)'(w_count) + (CW+2)'({w_live, 1'b0}) + (CW+2)'(2);
    // r_run holds requests off until the first edge after reset release
    assign imem_req_o  = r_run & ~taken_d_i & (w_live < 2'd2) & (w_need <= (CW+2)'(DEPTH_HW));
    assign imem_addr_o = r_fetch_pc;
    assign w_accept    = imem_req_o & imem_ready_i;

    assign w_push      = imem_rvalid_i & ~taken_d_i & (r_drop == 2'd0);
    assign w_push_n    = w_push ? (r_skip_hw ? 2'd1 : 2'd2) : 2'd0;

    assign w_many          = w_count >= CW'(2);
    assign instr_valid_f_o = w_many | ((w_count == CW'(1)) & ~is_full(w_head0));
    assign instruction_f_o = instr_valid_f_o ? {w_many ? w_head1 : 16'h0, w_head0} : 32'h0;

    assign w_consume = enable_i & instr_valid_f_o & ~taken_d_i;
    assign w_pop_n   = w_consume ? (is_compressed_d_i ? 2'd1 : 2'd2) : 2'd0;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_fetch_pc <= RESET_PC;
            r_skip_hw  <= 1'b0;
            r_run      <= 1'b0;
            r_outst    <= 2'd0;
            r_drop     <= 2'd0;
        end else begin
            r_run <= 1'b1;
            if (taken_d_i) begin
                // Everything still in flight belongs to the old path; a response landing now is already gone
                r_fetch_pc <= {redirection_d_i[31:2], 2'b00};
                r_skip_hw  <= redirection_d_i[1];
                r_outst    <= r_outst - {1'b0, imem_rvalid_i};
                r_drop     <= r_outst - {1'b0, imem_rvalid_i};
            end else begin
                if (w_accept)
                    r_fetch_pc <= r_fetch_pc + 32'd4;
                if (w_push)
                    r_skip_hw <= 1'b0;
                r_outst <= r_outst + {1'b0, w_accept} - {1'b0, imem_rvalid_i};
                if (imem_rvalid_i && r_drop != 2'd0)
                    r_drop <= r_drop - 2'd1;
            end
        end
    end

    if_fetch_buffer_hw_fifo #(.DEPTH(DEPTH_HW)) u_fifo (
        .clk         (clk),
        .resetn      (resetn),
        .i_clear     (taken_d_i),
        .i_push_n    (w_push_n),
        .i_push_data (r_skip_hw ? {16'h0, imem_rdata_i[31:16]} : imem_rdata_i),
        .i_pop_n     (w_pop_n),
        .o_count     (w_count),
        .o_head0     (w_head0),
        .o_head1     (w_head1)
    );

endmodule

// File: tb/tb_if_fetch_buffer.sv
// tb_if_fetch_buffer: scoreboard bench for if_fetch_buffer with an in-order memory model
module tb_if_fetch_buffer;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        imem_req_o;
    logic [31:0] imem_addr_o;
    logic        imem_ready_i = 1'b0;
    logic        imem_rvalid_i = 1'b0;
    logic [31:0] imem_rdata_i = 32'h0;
    logic        enable_i = 1'b0;
    logic        is_compressed_d_i = 1'b0;
    logic        taken_d_i = 1'b0;
    logic [31:0] redirection_d_i = 32'h0;
    logic [31:0] instruction_f_o;
    logic        instr_valid_f_o;

    always #5 clk = ~clk;

    if_fetch_buffer #(.DEPTH_HW(8), .RESET_PC(32'h0)) dut (
        .clk               (clk),
        .resetn            (resetn),
        .imem_req_o        (imem_req_o),
        .imem_addr_o       (imem_addr_o),
        .imem_ready_i      (imem_ready_i),
        .imem_rvalid_i     (imem_rvalid_i),
        .imem_rdata_i      (imem_rdata_i),
        .enable_i          (enable_i),
        .is_compressed_d_i (is_compressed_d_i),
        .taken_d_i         (taken_d_i),
        .redirection_d_i   (redirection_d_i),
        .instruction_f_o   (instruction_f_o),
        .instr_valid_f_o   (instr_valid_f_o)
    );

    typedef struct {
        logic [31:0] a;
        int          due;
    } req_t;

    req_t        pend[$];
    logic [31:0] sb[$];
    logic [31:0] acc_addr[$];
    int          cons_cyc[$];
    int          total = 0;
    int          bad = 0;
    int          cyc = 0;
    int          lat = 1;
    int          budget = -1;
    int          acc_cnt = 0;
    bit          autom = 1'b0;
    bit          en_user = 1'b1;
    bit          rdy_rand = 1'b0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        case (a)
            32'h0:   return 32'h00130013;
            32'h4:   return 32'h00000013;
            32'h8:   return 32'h45014581;
            32'h100: return 32'h0297BEEF;
            32'h104: return 32'h12340517;
            default: return {a[17:4] ^ 14'h1C3, a[5] ? 2'b01 : 2'b11,
                             a[15:2] ^ 14'h2A5, a[4] ? 2'b11 : 2'b01};
        endcase
    endfunction

    function automatic logic [15:0] hw_at(input logic [31:0] a);
        logic [31:0] w;
        w = mem_word({a[31:2], 2'b00});
        return a[1] ? w[31:16] : w[15:0];
    endfunction

    // Expected decode stream from a start PC; compressed entries keep only their 16 bits
    task automatic gen(input logic [31:0] pc, input int n);
        logic [15:0] h;
        sb.delete();
        pc[0] = 1'b0;
        for (int i = 0; i < n; i++) begin
            h = hw_at(pc);
            if (h[1:0] == 2'b11) begin
                sb.push_back({hw_at(pc + 32'd2), h});
                pc += 32'd4;
            end else begin
                sb.push_back({16'h0, h});
                pc += 32'd2;
            end
        end
    endtask

    // One cycle: entered and left at the falling edge
    task automatic step();
        req_t        r;
        logic [31:0] e;
        bit          c;
        if (autom) begin
            enable_i = en_user && sb.size() > 0;
            if (sb.size() > 0)
                is_compressed_d_i = sb[0][1:0] != 2'b11;
        end
        imem_rvalid_i = 1'b0;
        if (pend.size() > 0 && pend[0].due <= cyc) begin
            r = pend.pop_front();
            imem_rvalid_i = 1'b1;
            imem_rdata_i = mem_word(r.a);
        end
        imem_ready_i = budget != 0 && (!rdy_rand || $urandom_range(3) != 0);
        #1;
        if (autom && enable_i && instr_valid_f_o && !taken_d_i) begin
            e = sb.pop_front();
            c = e[1:0] != 2'b11;
            check("instr", c ? {16'h0, instruction_f_o[15:0]} : instruction_f_o, e);
            cons_cyc.push_back(cyc);
        end
        if (imem_req_o && imem_ready_i) begin
            check("addr_align", {30'h0, imem_addr_o[1:0]}, 32'h0);
            pend.push_back('{imem_addr_o, cyc + lat});
            acc_addr.push_back(imem_addr_o);
            acc_cnt++;
            if (budget > 0)
                budget--;
        end
        @(posedge clk);
        cyc++;
        @(negedge clk);
    endtask

    task automatic redir(input logic [31:0] t, input int n);
        taken_d_i = 1'b1;
        redirection_d_i = t;
        enable_i = 1'b0;
        step();
        taken_d_i = 1'b0;
        if (autom)
            gen(t, n);
    endtask

    task automatic run_until_empty(input int max);
        int n = 0;
        while (sb.size() > 0 && n < max) begin
            step();
            n++;
        end
        check("sb_drain", 32'(sb.size()), 32'h0);
    endtask

    task automatic wait_valid(input string tag, input int max);
        int n = 0;
        while (!instr_valid_f_o && n < max) begin
            step();
            n++;
        end
        check(tag, {31'h0, instr_valid_f_o}, 32'h1);
    endtask

    initial begin
        int n;
        int a0;
        @(negedge clk);
        step();
        step();
        #1;
        check("rst_req", {31'h0, imem_req_o}, 32'h0);
        check("rst_addr", imem_addr_o, 32'h0);
        check("rst_valid", {31'h0, instr_valid_f_o}, 32'h0);
        check("rst_instr", instruction_f_o, 32'h0);

        // Straight-line fetch from the reset PC
        resetn = 1'b1;
        autom = 1'b1;
        gen(32'h0, 6);
        run_until_empty(100);
        check("first_addr0", acc_addr[0], 32'h0);
        check("first_addr1", acc_addr[1], 32'h4);
        check("back_to_back", 32'(cons_cyc[1] - cons_cyc[0]), 32'h1);

        // Two compressed halfwords in one word, second seen alone
        autom = 1'b0;
        enable_i = 1'b0;
        budget = 1;
        redir(32'h8, 0);
        #1;
        check("redir_req", {31'h0, imem_req_o}, 32'h1);
        check("redir_addr", imem_addr_o, 32'h8);
        wait_valid("c2_valid", 20);
        check("c2_word", instruction_f_o, 32'h45014581);
        enable_i = 1'b1;
        is_compressed_d_i = 1'b1;
        step();
        enable_i = 1'b0;
        check("c2_single_valid", {31'h0, instr_valid_f_o}, 32'h1);
        check("c2_single", instruction_f_o, 32'h00004501);
        enable_i = 1'b1;
        step();
        enable_i = 1'b0;
        check("c2_empty", {31'h0, instr_valid_f_o}, 32'h0);

        // Redirect to a halfword target with two stale requests in flight
        autom = 1'b1;
        lat = 2;
        budget = -1;
        redir(32'h200, 20);
        n = 0;
        while (pend.size() < 2 && n < 20) begin
            step();
            n++;
        end
        check("two_outst", 32'(pend.size()), 32'h2);
        autom = 1'b0;
        enable_i = 1'b0;
        budget = 1;
        redir(32'h102, 0);
        #1;
        check("hw_redir_addr", imem_addr_o, 32'h100);
        n = 0;
        while ((budget != 0 || pend.size() > 0) && n < 30) begin
            step();
            n++;
        end
        step();
        step();
        check("straddle_wait", {31'h0, instr_valid_f_o}, 32'h0);
        check("straddle_zero", instruction_f_o, 32'h0);
        budget = 1;
        wait_valid("straddle_valid", 30);
        check("straddle_word", instruction_f_o, 32'h05170297);

        // Decode stall: fetch must throttle, then resume cleanly
        autom = 1'b1;
        lat = 1;
        budget = -1;
        rdy_rand = 1'b1;
        en_user = 1'b1;
        redir(32'h300, 30);
        for (int i = 0; i < 4; i++)
            step();
        en_user = 1'b0;
        rdy_rand = 1'b0;
        a0 = 0;
        for (int i = 0; i < 10; i++) begin
            if (i == 5)
                a0 = acc_cnt;
            step();
        end
        check("stall_noreq", 32'(acc_cnt - a0), 32'h0);
        check("stall_valid", {31'h0, instr_valid_f_o}, 32'h1);
        en_user = 1'b1;
        rdy_rand = 1'b1;
        run_until_empty(400);
        rdy_rand = 1'b0;

        // Asynchronous reset with a response still pending
        lat = 2;
        redir(32'h400, 20);
        n = 0;
        while (pend.size() == 0 && n < 10) begin
            step();
            n++;
        end
        check("pending_before_rst", {31'h0, pend.size() > 0}, 32'h1);
        resetn = 1'b0;
        #1;
        check("arst_req", {31'h0, imem_req_o}, 32'h0);
        check("arst_addr", imem_addr_o, 32'h0);
        check("arst_valid", {31'h0, instr_valid_f_o}, 32'h0);
        check("arst_instr", instruction_f_o, 32'h0);
        pend.delete();
        autom = 1'b0;
        enable_i = 1'b0;
        @(negedge clk);
        step();
        resetn = 1'b1;
        acc_addr.delete();
        n = 0;
        while (acc_addr.size() == 0 && n < 10) begin
            step();
            n++;
        end
        check("post_rst_req", 32'(acc_addr.size()), 32'h1);
        if (acc_addr.size() > 0)
            check("post_rst_addr", acc_addr[0], 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout got=%0d exp=%0d", cyc, 0);
        $fatal(1, "timeout");
    end

endmodule
